hadamard_row8: RTL

HADAMARD_ROW8 -- requirements
Module: hadamard_row8

---
 rtl/hadamard_row8.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hadamard_row8.sv
// hadamard_row8: 8-point unnormalised Walsh-Hadamard transform of one residual row.
// The transform is a three-level radix-2 butterfly. Each level has its own register
// stage, and a fourth register holds the published coefficients. A 3-bit row counter
// tags each output row with its position in the 8x8 block.
module hadamard_row8 #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    in_valid,
    input  logic signed [WIDTH:0]   diff_0,
    input  logic signed [WIDTH:0]   diff_1,
    input  logic signed [WIDTH:0]   diff_2,
    input  logic signed [WIDTH:0]   diff_3,
    input  logic signed [WIDTH:0]   diff_4,
    input  logic signed [WIDTH:0]   diff_5,
    input  logic signed [WIDTH:0]   diff_6,
    input  logic signed [WIDTH:0]   diff_7,
    output logic signed [WIDTH+3:0] had_0,
    output logic signed [WIDTH+3:0] had_1,
    output logic signed [WIDTH+3:0] had_2,
    output logic signed [WIDTH+3:0] had_3,
    output logic signed [WIDTH+3:0] had_4,
    output logic signed [WIDTH+3:0] had_5,
    output logic signed [WIDTH+3:0] had_6,
    output logic signed [WIDTH+3:0] had_7,
    output logic                    out_valid,
    output logic [2:0]              row_idx,
    output logic                    block_last
);

    localparam int W1 = WIDTH + 2;
    localparam int W2 = WIDTH + 3;
    localparam int W3 = WIDTH + 4;

    logic signed [WIDTH:0] w_d        [8];
    logic signed [W1-1:0]  w_s1_next  [8];
    logic signed [W2-1:0]  w_s2_next  [8];
    logic signed [W3-1:0]  w_s3_next  [8];

    logic signed [W1-1:0]  r_s1  [8];
    logic signed [W2-1:0]  r_s2  [8];
    logic signed [W3-1:0]  r_s3  [8];
    logic signed [W3-1:0]  r_had [8];

    logic       r_v1;
    logic       r_v2;
    logic       r_v3;
    logic       r_out_valid;
    logic       r_block_last;
    logic [2:0] r_row_idx;
    logic [2:0] r_row_cnt;

    assign w_d[0] = diff_0;
    assign w_d[1] = diff_1;
    assign w_d[2] = diff_2;
    assign w_d[3] = diff_3;
    assign w_d[4] = diff_4;
    assign w_d[5] = diff_5;
    assign w_d[6] = diff_6;
    assign w_d[7] = diff_7;

    // Butterfly levels. The lower index of each pair takes the sum and the upper
    // index takes the difference. Running the levels in this order leaves the
    // results in Sylvester (natural Hadamard) order. Every operand is sign-extended
    // to the wider width of its level before the add/subtract.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bfly
            if ((gi & 4) == 0) begin : g_l1_sum
                assign w_s1_next[gi] = W1'(w_d[gi]) + W1'(w_d[gi+4]);
            end else begin : g_l1_dif
                assign w_s1_next[gi] = W1'(w_d[gi-4]) - W1'(w_d[gi]);
            end

            if ((gi & 2) == 0) begin : g_l2_sum
                assign w_s2_next[gi] = W2'(r_s1[gi]) + W2'(r_s1[gi+2]);
            end else begin : g_l2_dif
                assign w_s2_next[gi] = W2'(r_s1[gi-2]) - W2'(r_s1[gi]);
            end

            if ((gi & 1) == 0) begin : g_l3_sum
                assign w_s3_next[gi] = W3'(r_s2[gi]) + W3'(r_s2[gi+1]);
            end else begin : g_l3_dif
                assign w_s3_next[gi] = W3'(r_s2[gi-1]) - W3'(r_s2[gi]);
            end
        end
    endgenerate

    // Butterfly pipeline registers with a valid bit that travels alongside each stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_s1 <= '{default: '0};
            r_s2 <= '{default: '0};
            r_s3 <= '{default: '0};
        end else if (ena) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_s1 <= w_s1_next;
            r_s2 <= w_s2_next;
            r_s3 <= w_s3_next;
        end
    end

    // Output stage. The coefficients and row index change only when a valid row
    // leaves stage 3; the row counter advances for that same event.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_had        <= '{default: '0};
            r_out_valid  <= 1'b0;
            r_block_last <= 1'b0;
            r_row_idx    <= 3'd0;
            r_row_cnt    <= 3'd0;
        end else if (ena) begin
            r_out_valid  <= r_v3;
            r_block_last <= r_v3 && (r_row_cnt == 3'd7);
            if (r_v3) begin
                r_had     <= r_s3;
                r_row_idx <= r_row_cnt;
                r_row_cnt <= r_row_cnt + 3'd1;
            end
        end
    end

    assign had_0      = r_had[0];
    assign had_1      = r_had[1];
    assign had_2      = r_had[2];
    assign had_3      = r_had[3];
    assign had_4      = r_had[4];
    assign had_5      = r_had[5];
    assign had_6      = r_had[6];
    assign had_7      = r_had[7];
    assign out_valid  = r_out_valid;
    assign row_idx    = r_row_idx;
    assign block_last = r_block_last;

endmodule
